mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Sequencer and arbiter for the tag's shared memory macro (EPC bank plus two sensor banks). It grants the single macro port to one of three requesters: backscatter read, EPC write from reader commands, and sensor/ADC sample write. For each granted access it drives the precharge/access/sense protocol (PC_B, WE, SE, RorW, mem_sel, mem_address, mem_data_out). It sits between the command/sensor logic and the memory macro and is the only block allowed to drive the macro port.

## Interface
- ADDR_W, 6, word address width
- DATA_W, 16, memory word width
- STARVE_LIMIT, 8, consecutive lost arbitrations before sensor write is promoted (1..15)

- clk  in  1  system clock, all logic on posedge
- reset_n  in  1  asynchronous, active-low reset
- rd_req  in  1  read request; held until rd_ack
- rd_sel  in  3  one-hot bank select for read (001 EPC, 010 sensor1, 100 sensor2)
- rd_addr  in  ADDR_W  read word address
- rd_ack  out  1  one-cycle pulse, read access finished
- rd_valid  out  1  one-cycle pulse coincident with rd_ack when data valid
- rd_data  out  DATA_W  captured read word, held until next read capture
- ew_req  in  1  EPC write request; bank fixed to 001
- ew_addr  in  ADDR_W  EPC write address
- ew_data  in  DATA_W  EPC write data
- ew_ack  out  1  one-cycle pulse, EPC write finished
- sw_req  in  1  sensor write request
- sw_sel  in  3  one-hot sensor bank (010 or 100)
- sw_addr  in  ADDR_W  sensor write address
- sw_data  in  DATA_W  {time_stamp, ADC_data}
- sw_ack  out  1  one-cycle pulse, sensor write finished
- err  out  1  one-cycle pulse with the ack of a rejected request
- busy  out  1  high in any state other than IDLE
- mem_read_in  in  DATA_W  macro read data
- mem_data_out  out  DATA_W  macro write data
- mem_address  out  ADDR_W  macro word line address
- mem_sel  out  3  macro bank select
- PC_B  out  1  precharge, active low
- WE  out  1  write enable
- SE  out  1  sense enable
- RorW  out  2  01 read, 10 write, 00 idle

## Operation
- States: IDLE, PRECH, ACCESS, DONE.
- IDLE: arbitrate among asserted requests and latch the winner's sel/addr/data and kind (read/write) into internal registers.
  - Priority: rd > ew > sw.
  - Exception: sw wins outright when starve_cnt == STARVE_LIMIT.
- Request validation in IDLE:
  - rd_sel must be exactly one-hot.
  - sw_sel must be 010 or 100.
  - A winner with an invalid select goes straight to DONE with err=1 and causes no PC_B/WE/SE/RorW activity.
- PRECH: PC_B=0; mem_sel and mem_address driven from the latched values; RorW=01 (read) or 10 (write).
- ACCESS: PC_B=1.
  - Read: SE=1.
  - Write: WE=1, mem_data_out = latched data.
- DONE:
  - WE=0, SE=0, RorW=00.
  - Read: rd_data <= mem_read_in, rd_valid=1.
  - Ack pulse to the granted requester (plus err if rejected).
  - Next state IDLE.
- mem_sel, mem_address and mem_data_out hold their last values outside PRECH/ACCESS.
- starve_cnt (4 bit, saturating at STARVE_LIMIT):
  - +1 in each IDLE arbitration where sw_req=1 and another requester wins.
  - Cleared when sw is granted or sw_req=0.
- A request dropped before its ack is a protocol violation. The arbiter uses its latched copy and still completes and acks.

## Timing
- Reset (reset_n low, takes effect immediately):
  - PC_B=1; WE=SE=0; RorW=00.
  - mem_sel=0, mem_address=0, mem_data_out=0.
  - rd_data=0; all acks, rd_valid, err and busy = 0.
  - State IDLE, starve_cnt=0.
- Reset mid-access aborts the access with no ack. Outputs return to reset values asynchronously.
- Latency: req sampled high at IDLE edge T → PRECH at T+1, ACCESS at T+2, DONE (ack) at T+3, IDLE at T+4.
- Rejected request: ack+err at T+1, IDLE at T+2.
- Requesters deassert req on the edge that samples ack high. Steady-state throughput is one access per 4 cycles.
- Simultaneous requests: the loser's req stays pending and is arbitrated in the next IDLE.
- rd_data updates only on a valid read's DONE edge.

## Test plan
- Single read: rd_req, rd_sel=001, rd_addr=5, mem_read_in=16'hA5C3 → PC_B=0 for 1 cycle with mem_address=5, then SE=1 for 1 cycle, then rd_ack=rd_valid=1 and rd_data=16'hA5C3, 3 cycles after grant.
- Single sensor write: sw_sel=010, sw_addr=3, sw_data=16'h1234 → RorW=10, WE=1 for exactly 1 cycle with mem_data_out=16'h1234 and mem_sel=010, then sw_ack.
- All three requests asserted together → order rd, ew, sw; acks 4 cycles apart.
- Starvation, STARVE_LIMIT=2: rd_req and sw_req held continuously, rd re-requests immediately after each ack → sw granted on the 3rd arbitration, ahead of rd.
- Invalid select: rd_sel=011 → rd_ack+err at T+1, no PC_B/SE activity, rd_data unchanged.
- reset_n pulled low during ACCESS of an EPC write → WE drops to 0 and PC_B=1 immediately, no ew_ack; after release, a new ew_req completes normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// Arbiter and precharge/access/sense sequencer for the tag's shared memory macro.
// Grants one of backscatter read, EPC write or sensor write per 4-cycle access.
module mem_arbiter #(
    parameter int ADDR_W       = 6,
    parameter int DATA_W       = 16,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              rd_req,
    input  logic [2:0]        rd_sel,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_ack,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    input  logic              ew_req,
    input  logic [ADDR_W-1:0] ew_addr,
    input  logic [DATA_W-1:0] ew_data,
    output logic              ew_ack,
    input  logic              sw_req,
    input  logic [2:0]        sw_sel,
    input  logic [ADDR_W-1:0] sw_addr,
    input  logic [DATA_W-1:0] sw_data,
    output logic              sw_ack,
    output logic              err,
    output logic              busy,
    input  logic [DATA_W-1:0] mem_read_in,
    output logic [DATA_W-1:0] mem_data_out,
    output logic [ADDR_W-1:0] mem_address,
    output logic [2:0]        mem_sel,
    output logic              PC_B,
    output logic              WE,
    output logic              SE,
    output logic [1:0]        RorW
);

    typedef enum logic [1:0] {IDLE, PRECH, ACCESS, DONE} state_t;
    typedef enum logic [1:0] {G_RD, G_EW, G_SW} grant_t;

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    state_t              state_q, state_d;
    grant_t              grant_q;
    logic                reject_q;
    logic [2:0]          mem_sel_q;
    logic [ADDR_W-1:0]   mem_address_q;
    logic [DATA_W-1:0]   mem_data_out_q;
    logic [DATA_W-1:0]   rd_data_q;
    logic [3:0]          starve_cnt_q;

    grant_t              win;
    logic                any_req;
    logic                win_ok;
    logic [2:0]          win_sel;
    logic [ADDR_W-1:0]   win_addr;
    logic [DATA_W-1:0]   win_data;
    logic                rd_sel_ok;
    logic                sw_sel_ok;

    assign rd_sel_ok = (rd_sel == 3'b001) || (rd_sel == 3'b010) || (rd_sel == 3'b100);
    assign sw_sel_ok = (sw_sel == 3'b010) || (sw_sel == 3'b100);
    assign any_req   = rd_req || ew_req || sw_req;

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        win      = G_RD;
        win_ok   = rd_sel_ok;
        win_sel  = rd_sel;
        win_addr = rd_addr;
        win_data = '0;
        if (sw_req && (starve_cnt_q == STARVE_MAX || !(rd_req || ew_req))) begin
            win      = G_SW;
            win_ok   = sw_sel_ok;
            win_sel  = sw_sel;
            win_addr = sw_addr;
            win_data = sw_data;
        end else if (!rd_req && ew_req) begin
            win      = G_EW;
            win_ok   = 1'b1;
            win_sel  = 3'b001;
            win_addr = ew_addr;
            win_data = ew_data;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req) state_d = win_ok ? PRECH : DONE;
            PRECH:   state_d = ACCESS;
            ACCESS:  state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            grant_q        <= G_RD;
            reject_q       <= 1'b0;
            mem_sel_q      <= '0;
            mem_address_q  <= '0;
            mem_data_out_q <= '0;
            rd_data_q      <= '0;
            starve_cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && any_req) begin
                grant_q  <= win;
                reject_q <= !win_ok;
                // Rejected requests must leave the macro port untouched.
                if (win_ok) begin
                    mem_sel_q     <= win_sel;
                    mem_address_q <= win_addr;
                    if (win != G_RD) mem_data_out_q <= win_data;
                end
            end
            if (state_q == ACCESS && grant_q == G_RD) rd_data_q <= mem_read_in;
            if (!sw_req) begin
                starve_cnt_q <= '0;
            end else if (state_q == IDLE && any_req) begin
                if (win == G_SW)                    starve_cnt_q <= '0;
                else if (starve_cnt_q != STARVE_MAX) starve_cnt_q <= starve_cnt_q + 4'd1;
            end
        end
    end

    logic is_write;
    logic active;
    logic done;

    assign is_write = (grant_q != G_RD);
    assign active   = (state_q == PRECH) || (state_q == ACCESS);
    assign done     = (state_q == DONE);

    assign busy         = (state_q != IDLE);
    assign PC_B         = (state_q != PRECH);
    assign WE           = (state_q == ACCESS) && is_write;
    assign SE           = (state_q == ACCESS) && !is_write;
    assign RorW         = active ? (is_write ? 2'b10 : 2'b01) : 2'b00;
    assign rd_ack       = done && (grant_q == G_RD);
    assign ew_ack       = done && (grant_q == G_EW);
    assign sw_ack       = done && (grant_q == G_SW);
    assign err          = done && reject_q;
    assign rd_valid     = rd_ack && !reject_q;
    assign rd_data      = rd_data_q;
    assign mem_sel      = mem_sel_q;
    assign mem_address  = mem_address_q;
    assign mem_data_out = mem_data_out_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset, read, writes, priority, starvation,
// rejected selects and reset during an access.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        rd_req, ew_req, sw_req;
    logic [2:0]  rd_sel, sw_sel;
    logic [5:0]  rd_addr, ew_addr, sw_addr;
    logic [15:0] ew_data, sw_data, mem_read_in;
    logic        rd_ack, rd_valid, ew_ack, sw_ack, err, busy;
    logic [15:0] rd_data, mem_data_out;
    logic [5:0]  mem_address;
    logic [2:0]  mem_sel;
    logic        PC_B, WE, SE;
    logic [1:0]  RorW;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(6), .DATA_W(16), .STARVE_LIMIT(2)) dut (
        .clk(clk), .reset_n(reset_n),
        .rd_req(rd_req), .rd_sel(rd_sel), .rd_addr(rd_addr),
        .rd_ack(rd_ack), .rd_valid(rd_valid), .rd_data(rd_data),
        .ew_req(ew_req), .ew_addr(ew_addr), .ew_data(ew_data), .ew_ack(ew_ack),
        .sw_req(sw_req), .sw_sel(sw_sel), .sw_addr(sw_addr), .sw_data(sw_data),
        .sw_ack(sw_ack), .err(err), .busy(busy),
        .mem_read_in(mem_read_in), .mem_data_out(mem_data_out),
        .mem_address(mem_address), .mem_sel(mem_sel),
        .PC_B(PC_B), .WE(WE), .SE(SE), .RorW(RorW)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2:0] acks();
        return {rd_ack, ew_ack, sw_ack};
    endfunction

    initial begin
        reset_n = 1'b0;
        rd_req = 0; ew_req = 0; sw_req = 0;
        rd_sel = 3'b001; sw_sel = 3'b010;
        rd_addr = 0; ew_addr = 0; sw_addr = 0;
        ew_data = 0; sw_data = 0; mem_read_in = 16'hA5C3;
        #12;
        check("rst_pcb", PC_B, 1);
        check("rst_we_se", {WE, SE}, 0);
        check("rst_rorw", RorW, 0);
        check("rst_sel", mem_sel, 0);
        check("rst_addr", mem_address, 0);
        check("rst_dout", mem_data_out, 0);
        check("rst_rddata", rd_data, 0);
        check("rst_flags", {acks(), rd_valid, err, busy}, 0);
        reset_n = 1'b1;
        step();

        // Single read
        rd_req = 1; rd_sel = 3'b001; rd_addr = 6'd5;
        step();
        check("rd_prech", {PC_B, SE, WE, RorW}, {1'b0, 1'b0, 1'b0, 2'b01});
        check("rd_prech_addr", {mem_sel, mem_address}, {3'b001, 6'd5});
        step();
        check("rd_access", {PC_B, SE, WE}, 3'b110);
        step();
        check("rd_done", {rd_ack, rd_valid, err, SE, RorW}, {1'b1, 1'b1, 1'b0, 1'b0, 2'b00});
        check("rd_data", rd_data, 16'hA5C3);
        rd_req = 0;
        step();
        check("rd_idle", {busy, rd_ack, rd_valid}, 0);

        // Single sensor write
        sw_req = 1; sw_sel = 3'b010; sw_addr = 6'd3; sw_data = 16'h1234;
        step();
        check("sw_prech", {PC_B, WE, RorW}, {1'b0, 1'b0, 2'b10});
        check("sw_prech_addr", {mem_sel, mem_address}, {3'b010, 6'd3});
        step();
        check("sw_access", {PC_B, WE, SE}, 3'b110);
        check("sw_dout", mem_data_out, 16'h1234);
        step();
        check("sw_done", {WE, RorW, acks(), err}, {1'b0, 2'b00, 3'b001, 1'b0});
        sw_req = 0;
        step();
        check("sw_idle", {busy, WE}, 0);

        // Three simultaneous requests: rd, ew, sw, 4 cycles apart
        rd_req = 1; rd_sel = 3'b100; rd_addr = 6'd7;
        ew_req = 1; ew_addr = 6'd8; ew_data = 16'hCAFE;
        sw_req = 1; sw_sel = 3'b100; sw_addr = 6'd9; sw_data = 16'h7777;
        step(); step(); step();
        check("all_ack1", acks(), 3'b100);
        rd_req = 0;
        step(); step();
        check("all_ew_sel", {mem_sel, mem_address}, {3'b001, 6'd8});
        step(); step();
        check("all_ack2", acks(), 3'b010);
        ew_req = 0;
        step(); step();
        check("all_sw_sel", {mem_sel, mem_address}, {3'b100, 6'd9});
        step(); step();
        check("all_ack3", acks(), 3'b001);
        sw_req = 0;
        step();

        // Starvation with limit 2: rd held, sw promoted on the 3rd arbitration
        mem_read_in = 16'h5A5A;
        rd_req = 1; rd_sel = 3'b001; rd_addr = 6'd1;
        sw_req = 1; sw_sel = 3'b010; sw_addr = 6'd2; sw_data = 16'h0042;
        step(); step(); step();
        check("stv_ack1", acks(), 3'b100);
        step(); step(); step(); step();
        check("stv_ack2", acks(), 3'b100);
        step(); step(); step(); step();
        check("stv_ack3", acks(), 3'b001);
        sw_req = 0;
        step(); step(); step(); step();
        check("stv_ack4", acks(), 3'b100);
        check("stv_rddata", rd_data, 16'h5A5A);
        rd_req = 0;
        step();

        // Invalid read select
        mem_read_in = 16'hFFFF;
        rd_req = 1; rd_sel = 3'b011; rd_addr = 6'd4;
        step();
        check("inv_rd_done", {rd_ack, err, rd_valid, busy}, 4'b1101);
        check("inv_rd_quiet", {PC_B, SE, WE, RorW}, {1'b1, 1'b0, 1'b0, 2'b00});
        rd_req = 0;
        step();
        check("inv_rd_idle", {busy, err}, 0);
        check("inv_rd_data", rd_data, 16'h5A5A);

        // Invalid sensor select
        sw_req = 1; sw_sel = 3'b001;
        step();
        check("inv_sw_done", {acks(), err, PC_B, WE}, {3'b001, 1'b1, 1'b1, 1'b0});
        sw_req = 0;
        step();

        // Reset during ACCESS of an EPC write
        ew_req = 1; ew_addr = 6'd9; ew_data = 16'hBEEF;
        step(); step();
        check("rst_ew_access", {WE, PC_B, mem_data_out}, {1'b1, 1'b1, 16'hBEEF});
        reset_n = 1'b0;
        #1;
        check("rst_ew_abort", {WE, PC_B, busy, ew_ack, RorW}, {1'b0, 1'b1, 1'b0, 1'b0, 2'b00});
        check("rst_ew_port", {mem_sel, mem_address, mem_data_out}, 0);
        ew_req = 0;
        step();
        check("rst_ew_noack", {ew_ack, busy}, 0);
        reset_n = 1'b1;
        step();
        check("rst_ew_idle", {ew_ack, busy}, 0);
        ew_req = 1; ew_addr = 6'd10; ew_data = 16'h0F0F;
        step();
        check("ew2_prech", {PC_B, RorW, mem_sel, mem_address}, {1'b0, 2'b10, 3'b001, 6'd10});
        step();
        check("ew2_access", {WE, mem_data_out}, {1'b1, 16'h0F0F});
        step();
        check("ew2_done", {acks(), err, WE}, {3'b010, 1'b0, 1'b0});
        ew_req = 0;
        step();
        check("ew2_idle", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
